fetch_stage: RTL and testbench

- Instruction fetch stage of the RV32I core; feeds decode, which drives the control unit from the opcode field.
- Owns the PC and issues word-aligned requests to instruction memory with a valid/ready handshake.
- Buffers up to two fetched instructions in a small FIFO and presents them to decode with valid/ready.
- Applies branch/jump redirects from execute: flushes buffered instructions and drops any in-flight response.

---
 rtl/rv32i_pkg.sv | 11 +
 rtl/fetch_buffer.sv | 41 ++++
 rtl/fetch_stage.sv | 71 +++++++
 tb/tb_fetch_stage.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I constants, opcodes and fetch state encoding
package rv32i_pkg;
    localparam int XLEN = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [31:0] NOP = 32'h0000_0013;
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} fetch_state_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-entry FIFO of {pc, instr}; head reads as zero when empty
module fetch_buffer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  logic [XLEN-1:0] push_pc,
    input  logic [31:0]     push_instr,
    output logic [1:0]      count,
    output logic [XLEN-1:0] head_pc,
    output logic [31:0]     head_instr
);
    logic [XLEN-1:0] pc0, pc1;
    logic [31:0] in0, in1;
    logic [1:0] slot;
    assign slot = count - 2'(pop);
    assign head_pc = count != 2'd0 ? pc0 : '0;
    assign head_instr = count != 2'd0 ? in0 : '0;
    always_ff @(posedge clk) begin
        if (rst || flush) count <= 2'd0;
        else count <= count + 2'(push) - 2'(pop);
    end
    // entry 0 is always the head; a pop shifts entry 1 down before any push lands
    always_ff @(posedge clk) begin
        if (pop) begin
            pc0 <= pc1;
            in0 <= in1;
        end
        if (push && slot == 2'd0) begin
            pc0 <= push_pc;
            in0 <= push_instr;
        end
        if (push && slot == 2'd1) begin
            pc1 <= push_pc;
            in1 <= push_instr;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I fetch with single outstanding imem request, 2-entry buffer and redirect flush
module fetch_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN = rv32i_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = rv32i_pkg::RESET_PC,
    parameter int BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instr,
    output logic [6:0]      id_opcode
);
    localparam logic [1:0] FULL = 2'(BUF_DEPTH);
    fetch_state_t state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic [1:0] count;
    logic req_fire, push, pop;
    assign imem_req_valid = state == S_REQ && count < FULL && !redirect_valid && !rst;
    assign imem_addr = pc;
    assign req_fire = imem_req_valid && imem_req_ready;
    assign push = state == S_WAIT && imem_rsp_valid && !redirect_valid;
    assign id_valid = count != 2'd0 && !redirect_valid;
    assign pop = id_valid && id_ready;
    assign id_opcode = id_instr[6:0];
    always_comb begin
        state_n = state;
        pc_n = pc;
        if (redirect_valid) begin
            pc_n = redirect_pc & ~XLEN'(3);
            state_n = state != S_REQ && !imem_rsp_valid ? S_DROP : S_REQ;
        end else if (req_fire) begin
            pc_n = pc + XLEN'(4);
            state_n = S_WAIT;
        end else if (state != S_REQ && imem_rsp_valid) begin
            state_n = S_REQ;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_REQ;
            pc <= RESET_PC;
        end else begin
            state <= state_n;
            pc <= pc_n;
        end
    end
    // pc already advanced past the outstanding request, so its address is pc-4
    fetch_buffer #(.XLEN(XLEN)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_pc   (pc - XLEN'(4)),
        .push_instr(imem_rsp_data),
        .count     (count),
        .head_pc   (id_pc),
        .head_instr(id_instr)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized and directed check of fetch_stage against a queue-based model
module tb_fetch_stage;
    logic clk = 0;
    logic rst, imem_req_valid, imem_req_ready, imem_rsp_valid, redirect_valid;
    logic id_valid, id_ready;
    logic [31:0] imem_addr, imem_rsp_data, redirect_pc, id_pc, id_instr;
    logic [6:0] id_opcode;
    logic v2, rsp2, idv2;
    logic [31:0] addr2, addr2q, idpc2, idin2;
    logic [6:0] idop2;
    int vectors = 0, miscompares = 0;
    logic [31:0] mq_pc[$], mq_in[$], req_log[$], pop_log[$], log2[$];
    logic m_out, m_drop;
    logic [31:0] m_pc, m_reqpc;
    logic pend;
    int pdly, lat;
    bit rand_lat;
    logic [31:0] paddr;
    int rl, pl;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr), .id_opcode(id_opcode)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst),
        .imem_req_valid(v2), .imem_req_ready(1'b1), .imem_addr(addr2),
        .imem_rsp_valid(rsp2), .imem_rsp_data(f(addr2q)),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .id_valid(idv2), .id_ready(1'b1), .id_pc(idpc2), .id_instr(idin2), .id_opcode(idop2)
    );

    function automatic logic [31:0] f(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h13;
    endfunction

    always @(posedge clk) begin
        rsp2 <= v2 && !rst;
        addr2q <= addr2;
    end
    always @(negedge clk) if (v2 && !rst && log2.size() < 4) log2.push_back(addr2);

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    task automatic cycle();
        logic e_req, e_idv, s_fire, s_pop, m_fire, m_pop;
        logic [31:0] e_pc, e_in, s_addr, s_idpc;
        @(negedge clk);
        imem_rsp_valid = pend && pdly == 0 && !rst;
        imem_rsp_data = imem_rsp_valid ? f(paddr) : $urandom;
        #1;
        e_req = !rst && !m_out && mq_pc.size() < 2 && !redirect_valid;
        e_idv = mq_pc.size() != 0 && !redirect_valid;
        e_pc = mq_pc.size() != 0 ? mq_pc[0] : 32'h0;
        e_in = mq_in.size() != 0 ? mq_in[0] : 32'h0;
        chk("imem_req_valid", {31'b0, imem_req_valid}, {31'b0, e_req});
        if (e_req) chk("imem_addr", imem_addr, m_pc);
        chk("id_valid", {31'b0, id_valid}, {31'b0, e_idv});
        chk("id_pc", id_pc, e_pc);
        chk("id_instr", id_instr, e_in);
        chk("id_opcode", {25'b0, id_opcode}, {25'b0, e_in[6:0]});
        s_fire = imem_req_valid && imem_req_ready;
        s_addr = imem_addr;
        s_pop = id_valid && id_ready;
        s_idpc = id_pc;
        m_fire = e_req && imem_req_ready;
        m_pop = e_idv && id_ready;
        @(posedge clk);
        if (s_fire) req_log.push_back(s_addr);
        if (s_pop) pop_log.push_back(s_idpc);
        if (rst || imem_rsp_valid) pend = 0;
        else if (pend) pdly--;
        if (!rst && s_fire) begin
            pend = 1;
            paddr = s_addr;
            pdly = rand_lat ? $urandom_range(0, 2) : lat;
        end
        if (rst) begin
            mq_pc.delete(); mq_in.delete();
            m_out = 0; m_drop = 0; m_pc = 32'h0;
        end else if (redirect_valid) begin
            mq_pc.delete(); mq_in.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
            if (m_out && !imem_rsp_valid) m_drop = 1;
            else begin m_out = 0; m_drop = 0; end
        end else begin
            if (m_pop) begin void'(mq_pc.pop_front()); void'(mq_in.pop_front()); end
            if (imem_rsp_valid && m_out) begin
                if (!m_drop) begin mq_pc.push_back(m_reqpc); mq_in.push_back(f(m_reqpc)); end
                m_out = 0; m_drop = 0;
            end
            if (m_fire) begin m_reqpc = m_pc; m_pc = m_pc + 4; m_out = 1; end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1; redirect_valid = 0;
        cycle(); cycle();
        rst = 0;
        req_log.delete(); pop_log.delete();
    endtask

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        return q.size() > i ? q[i] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        rst = 1; imem_req_ready = 1; id_ready = 1; redirect_valid = 0; redirect_pc = 0;
        imem_rsp_valid = 0; imem_rsp_data = 0; pend = 0; pdly = 0; lat = 0; rand_lat = 0;
        m_out = 0; m_drop = 0; m_pc = 0; m_reqpc = 0; paddr = 0;
        do_reset();
        rst = 1; #1;
        chk("reset_req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk("reset_id_valid", {31'b0, id_valid}, 32'h0);
        chk("reset_id_pc", id_pc, 32'h0);
        chk("reset_id_instr", id_instr, 32'h0);
        rst = 0; #1;
        chk("first_addr", imem_addr, 32'h0);
        // steady stream, 1-cycle imem
        for (int i = 0; i < 10; i++) cycle();
        chk("seq_req0", qat(req_log, 0), 32'h0);
        chk("seq_req1", qat(req_log, 1), 32'h4);
        chk("seq_req2", qat(req_log, 2), 32'h8);
        chk("seq_pop0", qat(pop_log, 0), 32'h0);
        chk("seq_pop1", qat(pop_log, 1), 32'h4);
        chk("seq_pop2", qat(pop_log, 2), 32'h8);
        chk("wrap_req0", qat(log2, 0), 32'hFFFF_FFFC);
        chk("wrap_req1", qat(log2, 1), 32'h0);
        // decode stalled: buffer fills to two
        do_reset();
        id_ready = 0;
        for (int i = 0; i < 10; i++) cycle();
        chk("full_req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk("full_id_pc", id_pc, 32'h0);
        chk("full_req_count", req_log.size(), 2);
        id_ready = 1;
        for (int i = 0; i < 10; i++) cycle();
        chk("full_pop0", qat(pop_log, 0), 32'h0);
        chk("full_pop1", qat(pop_log, 1), 32'h4);
        chk("full_req2", qat(req_log, 2), 32'h8);
        // redirect while 0x8 outstanding
        do_reset();
        lat = 2;
        for (int i = 0; i < 40 && req_log.size() < 3; i++) cycle();
        chk("drop_reached_0x8", qat(req_log, 2), 32'h8);
        rl = req_log.size(); pl = pop_log.size();
        redirect_valid = 1; redirect_pc = 32'h100;
        cycle();
        redirect_valid = 0; lat = 0;
        for (int i = 0; i < 20; i++) cycle();
        chk("drop_next_req", qat(req_log, rl), 32'h100);
        chk("drop_next_pop", qat(pop_log, pl), 32'h100);
        // redirect coincident with the only response
        do_reset();
        for (int i = 0; i < 10 && req_log.size() < 1; i++) cycle();
        redirect_valid = 1; redirect_pc = 32'h102;
        cycle();
        redirect_valid = 0;
        for (int i = 0; i < 10; i++) cycle();
        chk("coinc_next_req", qat(req_log, 1), 32'h100);
        chk("coinc_first_pop", qat(pop_log, 0), 32'h100);
        // imem backpressure holds the request
        do_reset();
        imem_req_ready = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_valid", {31'b0, imem_req_valid}, 32'h1);
            chk("stall_addr", imem_addr, 32'h0);
        end
        imem_req_ready = 1;
        // reset with a full buffer
        do_reset();
        id_ready = 0;
        for (int i = 0; i < 10; i++) cycle();
        rst = 1;
        cycle();
        rst = 0; #1;
        chk("midrst_id_valid", {31'b0, id_valid}, 32'h0);
        chk("midrst_addr", imem_addr, 32'h0);
        chk("midrst_req_valid", {31'b0, imem_req_valid}, 32'h1);
        // randomized traffic
        rand_lat = 1;
        for (int i = 0; i < 4000; i++) begin
            rst = $urandom_range(0, 99) == 0;
            imem_req_ready = $urandom_range(0, 9) < 7;
            id_ready = $urandom_range(0, 9) < 6;
            redirect_valid = $urandom_range(0, 19) == 0;
            redirect_pc = $urandom;
            cycle();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
